// File: rtl/mem_arbiter.sv
// Serialises fetch and load/store traffic onto a single-outstanding memory port.
// Define MEM_ARB_PERF_EN to enable the grant/cancel performance counters.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear_signal,
  input  logic        if_req,
  input  logic [31:0] if_a,
  output logic [63:0] if_d,
  output logic        if_done,
  input  logic        lsb_req,
  input  logic        lsb_wr,
  input  logic        lsb_signed,
  input  logic [1:0]  lsb_len,
  input  logic [31:0] lsb_a,
  input  logic [31:0] lsb_din,
  output logic [31:0] lsb_dout,
  output logic        lsb_done,
  output logic        mc_instr_signal,
  output logic [31:0] mc_instr_a,
  input  logic [63:0] mc_instr_d,
  input  logic        mc_instr_done,
  output logic        mc_lsb_signal,
  output logic        mc_lsb_wr,
  output logic        mc_lsb_signed,
  output logic [1:0]  mc_lsb_len,
  output logic [31:0] mc_lsb_a,
  output logic [31:0] mc_lsb_din,
  input  logic [31:0] mc_lsb_dout,
  input  logic        mc_lsb_done,
  output logic [31:0] perf_if_grants,
  output logic [31:0] perf_lsb_grants,
  output logic [31:0] perf_cancels
);

  typedef enum logic [1:0] {
    IDLE, WAIT_IF, WAIT_LSB, RESP
  } state_e;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      if_d_q, if_d_d;
  logic             if_done_q, if_done_d;
  logic [31:0]      lsb_dout_q, lsb_dout_d;
  logic             lsb_done_q, lsb_done_d;
  logic             ins_sig_q, ins_sig_d;
  logic [31:0]      ins_a_q, ins_a_d;
  logic             ls_sig_q, ls_sig_d;
  logic             ls_wr_q, ls_wr_d;
  logic             ls_sgn_q, ls_sgn_d;
  logic [1:0]       ls_len_q, ls_len_d;
  logic [31:0]      ls_a_q, ls_a_d;
  logic [31:0]      ls_din_q, ls_din_d;

  logic fetch_c, lsb_c, grant_if, grant_lsb;

  // Committed stores survive a flush; fetches and loads do not.
  assign fetch_c   = if_req & ~clear_signal;
  assign lsb_c     = lsb_req & (lsb_wr | ~clear_signal);
  assign grant_lsb = lsb_c & (~fetch_c | (cnt_q == LIMIT));
  assign grant_if  = fetch_c & ~grant_lsb;

  always_comb begin
    state_d    = state_q;
    cnt_d      = lsb_req ? cnt_q : '0;
    if_d_d     = if_d_q;
    if_done_d  = 1'b0;
    lsb_dout_d = lsb_dout_q;
    lsb_done_d = 1'b0;
    ins_sig_d  = 1'b0;
    ins_a_d    = ins_a_q;
    ls_sig_d   = 1'b0;
    ls_wr_d    = ls_wr_q;
    ls_sgn_d   = ls_sgn_q;
    ls_len_d   = ls_len_q;
    ls_a_d     = ls_a_q;
    ls_din_d   = ls_din_q;
    unique case (state_q)
      IDLE: begin
        if (grant_if) begin
          ins_sig_d = 1'b1;
          ins_a_d   = if_a;
          state_d   = WAIT_IF;
          if (lsb_req) cnt_d = cnt_q + 1'b1;
        end else if (grant_lsb) begin
          ls_sig_d = 1'b1;
          ls_wr_d  = lsb_wr;
          ls_sgn_d = lsb_signed;
          ls_len_d = lsb_len;
          ls_a_d   = lsb_a;
          ls_din_d = lsb_din;
          cnt_d    = '0;
          state_d  = WAIT_LSB;
        end
      end
      WAIT_IF: begin
        if (clear_signal) begin
          state_d = IDLE;
        end else if (mc_instr_done) begin
          if_d_d    = mc_instr_d;
          if_done_d = 1'b1;
          state_d   = RESP;
        end
      end
      WAIT_LSB: begin
        if (clear_signal && !ls_wr_q) begin
          state_d = IDLE;
        end else if (mc_lsb_done) begin
          lsb_dout_d = mc_lsb_dout;
          lsb_done_d = 1'b1;
          state_d    = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      if_d_q     <= '0;
      if_done_q  <= 1'b0;
      lsb_dout_q <= '0;
      lsb_done_q <= 1'b0;
      ins_sig_q  <= 1'b0;
      ins_a_q    <= '0;
      ls_sig_q   <= 1'b0;
      ls_wr_q    <= 1'b0;
      ls_sgn_q   <= 1'b0;
      ls_len_q   <= '0;
      ls_a_q     <= '0;
      ls_din_q   <= '0;
    end else if (rdy_in) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      if_d_q     <= if_d_d;
      if_done_q  <= if_done_d;
      lsb_dout_q <= lsb_dout_d;
      lsb_done_q <= lsb_done_d;
      ins_sig_q  <= ins_sig_d;
      ins_a_q    <= ins_a_d;
      ls_sig_q   <= ls_sig_d;
      ls_wr_q    <= ls_wr_d;
      ls_sgn_q   <= ls_sgn_d;
      ls_len_q   <= ls_len_d;
      ls_a_q     <= ls_a_d;
      ls_din_q   <= ls_din_d;
    end
  end

  assign if_d            = if_d_q;
  assign if_done         = if_done_q;
  assign lsb_dout        = lsb_dout_q;
  assign lsb_done        = lsb_done_q;
  assign mc_instr_signal = ins_sig_q;
  assign mc_instr_a      = ins_a_q;
  assign mc_lsb_signal   = ls_sig_q;
  assign mc_lsb_wr       = ls_wr_q;
  assign mc_lsb_signed   = ls_sgn_q;
  assign mc_lsb_len      = ls_len_q;
  assign mc_lsb_a        = ls_a_q;
  assign mc_lsb_din      = ls_din_q;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] pif_q, plsb_q, pcan_q;
  logic        ev_if, ev_lsb, ev_can;

  assign ev_if  = (state_q == IDLE) & grant_if;
  assign ev_lsb = (state_q == IDLE) & grant_lsb;
  assign ev_can = clear_signal &
                  ((state_q == WAIT_IF) |
                   ((state_q == WAIT_LSB) & ~ls_wr_q));

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pif_q  <= '0;
      plsb_q <= '0;
      pcan_q <= '0;
    end else if (rdy_in) begin
      pif_q  <= pif_q + {31'b0, ev_if};
      plsb_q <= plsb_q + {31'b0, ev_lsb};
      pcan_q <= pcan_q + {31'b0, ev_can};
    end
  end

  assign perf_if_grants  = pif_q;
  assign perf_lsb_grants = plsb_q;
  assign perf_cancels    = pcan_q;
`else
  assign perf_if_grants  = 32'h0;
  assign perf_lsb_grants = 32'h0;
  assign perf_cancels    = 32'h0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed-vector bench for mem_arbiter: priority, starvation, flush,
// stall and reset behaviour against hand-computed expectations.
module tb_mem_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear_signal;
  logic        if_req;
  logic [31:0] if_a;
  logic [63:0] if_d;
  logic        if_done;
  logic        lsb_req, lsb_wr, lsb_signed;
  logic [1:0]  lsb_len;
  logic [31:0] lsb_a, lsb_din, lsb_dout;
  logic        lsb_done;
  logic        mc_instr_signal;
  logic [31:0] mc_instr_a;
  logic [63:0] mc_instr_d;
  logic        mc_instr_done;
  logic        mc_lsb_signal, mc_lsb_wr, mc_lsb_signed;
  logic [1:0]  mc_lsb_len;
  logic [31:0] mc_lsb_a, mc_lsb_din, mc_lsb_dout;
  logic        mc_lsb_done;
  logic [31:0] perf_if_grants, perf_lsb_grants, perf_cancels;

  int vecs = 0;
  int errs = 0;

  mem_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .clear_signal(clear_signal),
    .if_req(if_req), .if_a(if_a), .if_d(if_d), .if_done(if_done),
    .lsb_req(lsb_req), .lsb_wr(lsb_wr), .lsb_signed(lsb_signed),
    .lsb_len(lsb_len), .lsb_a(lsb_a), .lsb_din(lsb_din),
    .lsb_dout(lsb_dout), .lsb_done(lsb_done),
    .mc_instr_signal(mc_instr_signal), .mc_instr_a(mc_instr_a),
    .mc_instr_d(mc_instr_d), .mc_instr_done(mc_instr_done),
    .mc_lsb_signal(mc_lsb_signal), .mc_lsb_wr(mc_lsb_wr),
    .mc_lsb_signed(mc_lsb_signed), .mc_lsb_len(mc_lsb_len),
    .mc_lsb_a(mc_lsb_a), .mc_lsb_din(mc_lsb_din),
    .mc_lsb_dout(mc_lsb_dout), .mc_lsb_done(mc_lsb_done),
    .perf_if_grants(perf_if_grants),
    .perf_lsb_grants(perf_lsb_grants),
    .perf_cancels(perf_cancels)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    rdy_in = 1'b1; clear_signal = 1'b0;
    if_req = 1'b0; if_a = '0;
    lsb_req = 1'b0; lsb_wr = 1'b0; lsb_signed = 1'b0;
    lsb_len = '0; lsb_a = '0; lsb_din = '0;
    mc_instr_d = '0; mc_instr_done = 1'b0;
    mc_lsb_dout = '0; mc_lsb_done = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    if_req = 1'b1; if_a = 32'h1234;
    lsb_req = 1'b1; lsb_a = 32'h88; lsb_din = 32'h77;
    rst_in = 1'b1;
    step();
    step();
    vecs++;
    if ({if_done, lsb_done, mc_instr_signal, mc_lsb_signal} !== 4'b0) begin
      errs++;
      $display("FAIL reset_pulses: got %b want 0000",
        {if_done, lsb_done, mc_instr_signal, mc_lsb_signal});
    end
    vecs++;
    if ({if_d, lsb_dout} !== 96'b0) begin
      errs++;
      $display("FAIL reset_data: got %h want 0", {if_d, lsb_dout});
    end
    vecs++;
    if ({mc_instr_a, mc_lsb_a, mc_lsb_din, mc_lsb_len,
         mc_lsb_wr, mc_lsb_signed} !== 100'b0) begin
      errs++;
      $display("FAIL reset_mc_fields: got %h want 0",
        {mc_instr_a, mc_lsb_a, mc_lsb_din, mc_lsb_len,
         mc_lsb_wr, mc_lsb_signed});
    end
    vecs++;
    if ({perf_if_grants, perf_lsb_grants, perf_cancels} !== 96'b0) begin
      errs++;
      $display("FAIL reset_perf: got %h want 0",
        {perf_if_grants, perf_lsb_grants, perf_cancels});
    end
    rst_in = 1'b0;
    idle_inputs();
    step();
  endtask

  task automatic test_fetch();
    do_reset();
    if_req = 1'b1; if_a = 32'h1000;
    step();
    vecs++;
    if ({mc_instr_signal, mc_instr_a, mc_lsb_signal} !== {1'b1, 32'h1000, 1'b0}) begin
      errs++;
      $display("FAIL fetch_issue: got %b/%h want 1/00001000",
        mc_instr_signal, mc_instr_a);
    end
    step();
    vecs++;
    if (mc_instr_signal !== 1'b0) begin
      errs++;
      $display("FAIL fetch_issue_width: got %b want 0", mc_instr_signal);
    end
    repeat (6) step();
    vecs++;
    if (if_done !== 1'b0) begin
      errs++;
      $display("FAIL fetch_early_done: got %b want 0", if_done);
    end
    mc_instr_done = 1'b1; mc_instr_d = 64'h0011223344556677;
    step();
    mc_instr_done = 1'b0; if_req = 1'b0;
    vecs++;
    if ({if_done, lsb_done, if_d} !== {2'b10, 64'h0011223344556677}) begin
      errs++;
      $display("FAIL fetch_done: got %b%b/%h want 10/0011223344556677",
        if_done, lsb_done, if_d);
    end
    step();
    vecs++;
    if ({if_done, if_d} !== {1'b0, 64'h0011223344556677}) begin
      errs++;
      $display("FAIL fetch_done_width: got %b/%h want 0/0011223344556677",
        if_done, if_d);
    end
  endtask

  task automatic test_starvation();
    int nf = 0;
    int nl = 0;
    int fb0 = -1;
    int fb1 = -1;
    bit both = 1'b0;
    logic [31:0] la = '0;
    do_reset();
    if_req = 1'b1; if_a = 32'h4000;
    lsb_req = 1'b1; lsb_wr = 1'b0; lsb_a = 32'h20; lsb_len = 2'd1;
    for (int c = 0; c < 300 && nl < 2; c++) begin
      step();
      mc_instr_done = 1'b0; mc_lsb_done = 1'b0;
      if (if_done && lsb_done) both = 1'b1;
      if (mc_instr_signal) begin
        nf++;
        mc_instr_done = 1'b1; mc_instr_d = 64'hA5A5;
      end
      if (mc_lsb_signal) begin
        if (nl == 0) fb0 = nf; else fb1 = nf;
        nl++;
        la = mc_lsb_a;
        mc_lsb_done = 1'b1; mc_lsb_dout = 32'h12345678;
      end
    end
    step();
    mc_lsb_done = 1'b0; if_req = 1'b0; lsb_req = 1'b0;
    vecs++;
    if (nl !== 2) begin
      errs++;
      $display("FAIL starve_timeout: got %0d lsb grants want 2", nl);
    end
    vecs++;
    if (fb0 !== 4) begin
      errs++;
      $display("FAIL starve_first: got %0d fetch grants want 4", fb0);
    end
    vecs++;
    if (fb1 !== 8) begin
      errs++;
      $display("FAIL starve_counter_reset: got %0d fetch grants want 8", fb1);
    end
    vecs++;
    if (la !== 32'h20) begin
      errs++;
      $display("FAIL starve_lsb_addr: got %h want 00000020", la);
    end
    vecs++;
    if ({both, lsb_done, if_done, lsb_dout} !== {3'b010, 32'h12345678}) begin
      errs++;
      $display("FAIL starve_lsb_done: got %b%b%b/%h want 010/12345678",
        both, lsb_done, if_done, lsb_dout);
    end
    step();
  endtask

  task automatic test_clear_load();
    do_reset();
    lsb_req = 1'b1; lsb_wr = 1'b0; lsb_a = 32'h40; lsb_len = 2'd1;
    step();
    vecs++;
    if ({mc_lsb_signal, mc_lsb_wr, mc_lsb_a} !== {2'b10, 32'h40}) begin
      errs++;
      $display("FAIL load_issue: got %b%b/%h want 10/00000040",
        mc_lsb_signal, mc_lsb_wr, mc_lsb_a);
    end
    clear_signal = 1'b1; lsb_req = 1'b0;
    step();
    vecs++;
    if (lsb_done !== 1'b0) begin
      errs++;
      $display("FAIL load_clear_done: got %b want 0", lsb_done);
    end
    clear_signal = 1'b0;
    mc_lsb_done = 1'b1; mc_lsb_dout = 32'hBAD;
    if_req = 1'b1; if_a = 32'h5000;
    step();
    mc_lsb_done = 1'b0;
    vecs++;
    if ({mc_instr_signal, lsb_done} !== 2'b10) begin
      errs++;
      $display("FAIL load_clear_idle: got %b%b want 10",
        mc_instr_signal, lsb_done);
    end
`ifdef MEM_ARB_PERF_EN
    vecs++;
    if ({perf_cancels, perf_lsb_grants, perf_if_grants} !== {32'd1, 32'd1, 32'd1}) begin
      errs++;
      $display("FAIL perf_counts: got %0d/%0d/%0d want 1/1/1",
        perf_cancels, perf_lsb_grants, perf_if_grants);
    end
`else
    vecs++;
    if ({perf_cancels, perf_lsb_grants, perf_if_grants} !== 96'b0) begin
      errs++;
      $display("FAIL perf_tied: got %h want 0",
        {perf_cancels, perf_lsb_grants, perf_if_grants});
    end
`endif
    step();
    vecs++;
    if (lsb_done !== 1'b0) begin
      errs++;
      $display("FAIL load_late_done: got %b want 0", lsb_done);
    end
    if_req = 1'b0;
  endtask

  task automatic test_clear_store();
    do_reset();
    lsb_req = 1'b1; lsb_wr = 1'b1; lsb_len = 2'd3;
    lsb_a = 32'h30004; lsb_din = 32'hDEADBEEF;
    step();
    vecs++;
    if ({mc_lsb_signal, mc_lsb_wr, mc_lsb_len, mc_lsb_a, mc_lsb_din} !==
        {2'b11, 2'd3, 32'h30004, 32'hDEADBEEF}) begin
      errs++;
      $display("FAIL store_issue: got %b%b%0d/%h/%h want 113/00030004/deadbeef",
        mc_lsb_signal, mc_lsb_wr, mc_lsb_len, mc_lsb_a, mc_lsb_din);
    end
    clear_signal = 1'b1;
    step();
    clear_signal = 1'b0;
    step();
    vecs++;
    if ({lsb_done, mc_lsb_signal} !== 2'b00) begin
      errs++;
      $display("FAIL store_wait: got %b%b want 00", lsb_done, mc_lsb_signal);
    end
    mc_lsb_done = 1'b1; clear_signal = 1'b1;
    step();
    vecs++;
    if ({lsb_done, if_done} !== 2'b10) begin
      errs++;
      $display("FAIL store_done: got %b%b want 10", lsb_done, if_done);
    end
    mc_lsb_done = 1'b0; clear_signal = 1'b0; lsb_req = 1'b0;
    step();
    vecs++;
    if (lsb_done !== 1'b0) begin
      errs++;
      $display("FAIL store_done_once: got %b want 0", lsb_done);
    end
  endtask

  task automatic test_rdy_stall();
    do_reset();
    if_req = 1'b1; if_a = 32'h2000;
    step();
    rdy_in = 1'b0;
    step();
    vecs++;
    if ({mc_instr_signal, mc_instr_a, if_done} !== {1'b1, 32'h2000, 1'b0}) begin
      errs++;
      $display("FAIL stall_hold: got %b/%h/%b want 1/00002000/0",
        mc_instr_signal, mc_instr_a, if_done);
    end
    mc_instr_done = 1'b1; mc_instr_d = 64'hFFFF;
    step();
    mc_instr_done = 1'b0;
    repeat (3) step();
    vecs++;
    if ({mc_instr_signal, if_done, if_d} !== {2'b10, 64'h0}) begin
      errs++;
      $display("FAIL stall_frozen: got %b%b/%h want 10/0",
        mc_instr_signal, if_done, if_d);
    end
    rdy_in = 1'b1;
    step();
    vecs++;
    if ({mc_instr_signal, if_done} !== 2'b00) begin
      errs++;
      $display("FAIL stall_resume: got %b%b want 00", mc_instr_signal, if_done);
    end
    mc_instr_done = 1'b1; mc_instr_d = 64'h8877665544332211;
    step();
    mc_instr_done = 1'b0; if_req = 1'b0;
    vecs++;
    if ({if_done, if_d} !== {1'b1, 64'h8877665544332211}) begin
      errs++;
      $display("FAIL stall_done: got %b/%h want 1/8877665544332211",
        if_done, if_d);
    end
    step();
  endtask

  task automatic test_reset_wait_lsb();
    do_reset();
    lsb_req = 1'b1; lsb_wr = 1'b0; lsb_a = 32'h50;
    step();
    vecs++;
    if ({mc_lsb_signal, mc_lsb_a} !== {1'b1, 32'h50}) begin
      errs++;
      $display("FAIL rstlsb_issue: got %b/%h want 1/00000050",
        mc_lsb_signal, mc_lsb_a);
    end
    step();
    rst_in = 1'b1;
    step();
    vecs++;
    if ({mc_lsb_signal, mc_lsb_a, lsb_done, lsb_dout} !== 66'b0) begin
      errs++;
      $display("FAIL rstlsb_clear: got %b/%h/%b/%h want 0",
        mc_lsb_signal, mc_lsb_a, lsb_done, lsb_dout);
    end
    rst_in = 1'b0; lsb_req = 1'b0;
    mc_lsb_done = 1'b1; mc_lsb_dout = 32'h55;
    step();
    mc_lsb_done = 1'b0;
    vecs++;
    if ({lsb_done, lsb_dout} !== 33'b0) begin
      errs++;
      $display("FAIL rstlsb_no_done: got %b/%h want 0/0", lsb_done, lsb_dout);
    end
  endtask

  task automatic test_clear_idle();
    do_reset();
    clear_signal = 1'b1;
    if_req = 1'b1; lsb_req = 1'b1; lsb_wr = 1'b0;
    step();
    vecs++;
    if ({mc_instr_signal, mc_lsb_signal} !== 2'b00) begin
      errs++;
      $display("FAIL clear_mask: got %b%b want 00",
        mc_instr_signal, mc_lsb_signal);
    end
    lsb_wr = 1'b1; lsb_a = 32'h60;
    step();
    vecs++;
    if ({mc_instr_signal, mc_lsb_signal, mc_lsb_wr, mc_lsb_a} !==
        {3'b011, 32'h60}) begin
      errs++;
      $display("FAIL clear_store_grant: got %b%b%b/%h want 011/00000060",
        mc_instr_signal, mc_lsb_signal, mc_lsb_wr, mc_lsb_a);
    end
    clear_signal = 1'b0; if_req = 1'b0; mc_lsb_done = 1'b1;
    step();
    mc_lsb_done = 1'b0; lsb_req = 1'b0;
    vecs++;
    if ({lsb_done, if_done} !== 2'b10) begin
      errs++;
      $display("FAIL clear_store_done: got %b%b want 10", lsb_done, if_done);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_starvation();
    test_clear_load();
    test_clear_store();
    test_rdy_stall();
    test_reset_wait_lsb();
    test_clear_idle();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
